// File: rtl/em_stage_hilo.sv
// E->M pipeline register with a multi-cycle multiply/divide unit and HI/LO pair.
module em_stage_hilo #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      IR_E,
  input  logic [WIDTH-1:0] PC_E,
  input  logic [WIDTH-1:0] PC8_E,
  input  logic [WIDTH-1:0] RS_E,
  input  logic [WIDTH-1:0] RT_E,
  input  logic [WIDTH-1:0] AO_E,
  input  logic             temp_E,
  input  logic             flush_E,
  output logic [31:0]      IR_M,
  output logic [WIDTH-1:0] PC_M,
  output logic [WIDTH-1:0] PC8_M,
  output logic [WIDTH-1:0] AO_M,
  output logic [WIDTH-1:0] RT_M,
  output logic             temp_M,
  output logic             valid_M,
  output logic             busy,
  output logic             md_stall,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned PROD_W  = 2 * WIDTH;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nx;
  logic               w_start;
  logic               w_done;

  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_pend_hi;
  logic [WIDTH-1:0]   r_pend_lo;
  logic               r_pend_we;

  logic               w_rtype;
  logic [5:0]         w_func;
  logic               w_mfhi, w_mthi, w_mflo, w_mtlo, w_mult, w_div, w_is_md;
  logic               w_signed_op;
  logic               w_advance;

  logic [PROD_W-1:0]  w_prod;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_num, w_den;
  logic [WIDTH-1:0]   w_q_mag, w_r_mag, w_q, w_r;
  logic               w_div_zero;

  // Instruction decode of the E-stage bundle.
  always_comb begin
    w_rtype     = (IR_E[31:26] == 6'd0);
    w_func      = IR_E[5:0];
    w_mfhi      = w_rtype && (w_func == F_MFHI);
    w_mthi      = w_rtype && (w_func == F_MTHI);
    w_mflo      = w_rtype && (w_func == F_MFLO);
    w_mtlo      = w_rtype && (w_func == F_MTLO);
    w_mult      = w_rtype && ((w_func == F_MULT) || (w_func == F_MULTU));
    w_div       = w_rtype && ((w_func == F_DIV) || (w_func == F_DIVU));
    w_is_md     = w_mfhi || w_mthi || w_mflo || w_mtlo || w_mult || w_div;
    w_signed_op = ~w_func[0];
  end

  assign busy      = (r_state == S_RUN);
  assign md_stall  = busy && w_is_md && !flush_E;
  assign w_advance = !flush_E && !md_stall;
  assign hi_out    = r_hi;
  assign lo_out    = r_lo;

  // Multiply and divide datapaths; signed division works on magnitudes, then fixes signs.
  always_comb begin
    if (w_signed_op) begin
      w_prod = {{WIDTH{RS_E[WIDTH-1]}}, RS_E} * {{WIDTH{RT_E[WIDTH-1]}}, RT_E};
    end else begin
      w_prod = {{WIDTH{1'b0}}, RS_E} * {{WIDTH{1'b0}}, RT_E};
    end
    w_abs_a    = RS_E[WIDTH-1] ? -RS_E : RS_E;
    w_abs_b    = RT_E[WIDTH-1] ? -RT_E : RT_E;
    w_div_zero = (RT_E == '0);
    w_num      = w_signed_op ? w_abs_a : RS_E;
    w_den      = w_div_zero ? WIDTH'(1) : (w_signed_op ? w_abs_b : RT_E);
    w_q_mag    = w_num / w_den;
    w_r_mag    = w_num % w_den;
    w_q        = (w_signed_op && (RS_E[WIDTH-1] ^ RT_E[WIDTH-1])) ? -w_q_mag : w_q_mag;
    w_r        = (w_signed_op && RS_E[WIDTH-1]) ? -w_r_mag : w_r_mag;
  end

  // FSM state and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // FSM next state: accept an md op when idle and advancing, count down while running.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_start    = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_advance && (w_mult || w_div)) begin
          w_start    = 1'b1;
          w_state_nx = S_RUN;
          w_cnt_nx   = w_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end
      end
      S_RUN: begin
        w_cnt_nx = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_done     = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // Pending result captured at acceptance; divide by zero suppresses the write-back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_we <= 1'b0;
    end else if (w_start) begin
      r_pend_hi <= w_mult ? w_prod[PROD_W-1:WIDTH] : w_r;
      r_pend_lo <= w_mult ? w_prod[WIDTH-1:0] : w_q;
      r_pend_we <= w_mult || !w_div_zero;
    end
  end

  // HI/LO update from completion or from mthi/mtlo.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_done) begin
      if (r_pend_we) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end else if (w_advance) begin
      if (w_mthi) r_hi <= RS_E;
      if (w_mtlo) r_lo <= RS_E;
    end
  end

  // E->M bundle register; bubble on flush or md stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      IR_M    <= '0;
      PC_M    <= '0;
      PC8_M   <= '0;
      AO_M    <= '0;
      RT_M    <= '0;
      temp_M  <= 1'b0;
      valid_M <= 1'b0;
    end else if (!w_advance) begin
      IR_M    <= '0;
      PC_M    <= '0;
      PC8_M   <= '0;
      AO_M    <= '0;
      RT_M    <= '0;
      temp_M  <= 1'b0;
      valid_M <= 1'b0;
    end else begin
      IR_M    <= IR_E;
      PC_M    <= PC_E;
      PC8_M   <= PC8_E;
      AO_M    <= w_mfhi ? r_hi : (w_mflo ? r_lo : AO_E);
      RT_M    <= RT_E;
      temp_M  <= temp_E;
      valid_M <= 1'b1;
    end
  end

endmodule

// File: tb/tb_em_stage_hilo.sv
// Directed testbench for em_stage_hilo.
module tb_em_stage_hilo;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR_E, PC_E, PC8_E, RS_E, RT_E, AO_E;
  logic        temp_E, flush_E;
  logic [31:0] IR_M, PC_M, PC8_M, AO_M, RT_M;
  logic        temp_M, valid_M, busy, md_stall;
  logic [31:0] hi_out, lo_out;

  int checks = 0;
  int errors = 0;

  em_stage_hilo #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset),
    .IR_E(IR_E), .PC_E(PC_E), .PC8_E(PC8_E), .RS_E(RS_E), .RT_E(RT_E), .AO_E(AO_E),
    .temp_E(temp_E), .flush_E(flush_E),
    .IR_M(IR_M), .PC_M(PC_M), .PC8_M(PC8_M), .AO_M(AO_M), .RT_M(RT_M),
    .temp_M(temp_M), .valid_M(valid_M), .busy(busy), .md_stall(md_stall),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rir(input logic [5:0] f);
    return {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, f};
  endfunction

  localparam logic [31:0] I_MFHI  = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h10};
  localparam logic [31:0] I_MTHI  = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h11};
  localparam logic [31:0] I_MFLO  = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h12};
  localparam logic [31:0] I_MULT  = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h18};
  localparam logic [31:0] I_MULTU = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h19};
  localparam logic [31:0] I_DIV   = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h1A};
  localparam logic [31:0] I_DIVU  = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h1B};
  localparam logic [31:0] I_ADD   = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ir, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] ao, input logic fl);
    IR_E    = ir;
    RS_E    = rs;
    RT_E    = rt;
    AO_E    = ao;
    PC_E    = 32'h0000_0400;
    PC8_E   = 32'h0000_0408;
    temp_E  = 1'b1;
    flush_E = fl;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    issue(I_ADD, 32'd1, 32'd2, 32'h55, 1'b0);
    tick();
    tick();
    checks++; if (IR_M !== 32'd0) begin errors++; $display("FAIL reset_ir: got %h want 0", IR_M); end
    checks++; if (AO_M !== 32'd0) begin errors++; $display("FAIL reset_ao: got %h want 0", AO_M); end
    checks++; if (valid_M !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_M); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if ({hi_out, lo_out} !== 64'd0) begin errors++; $display("FAIL reset_hilo: got %h/%h want 0/0", hi_out, lo_out); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    issue(I_MULT, 32'hFFFF_FFFF, 32'd2, 32'h0, 1'b0);
    tick();
    checks++; if (valid_M !== 1'b1 || IR_M !== I_MULT) begin errors++; $display("FAIL mult_accept: got v=%b ir=%h want 1/%h", valid_M, IR_M, I_MULT); end
    checks++; if ({PC_M, PC8_M, RT_M, temp_M} !== {32'h400, 32'h408, 32'd2, 1'b1}) begin errors++; $display("FAIL mult_bundle: got %h %h %h %b", PC_M, PC8_M, RT_M, temp_M); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy: got %b want 1", busy); end
    issue(I_MFHI, 32'd0, 32'd0, 32'hAAAA, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (md_stall !== 1'b1) begin errors++; $display("FAIL mult_stall%0d: got %b want 1", i, md_stall); end
      tick();
      checks++; if (valid_M !== 1'b0) begin errors++; $display("FAIL mult_bubble%0d: got %b want 0", i, valid_M); end
    end
    #1;
    checks++; if (busy !== 1'b0 || md_stall !== 1'b0) begin errors++; $display("FAIL mult_done: got busy=%b stall=%b want 0/0", busy, md_stall); end
    checks++; if (hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_hilo: got %h/%h want ffffffff/fffffffe", hi_out, lo_out); end
    tick();
    checks++; if (AO_M !== 32'hFFFF_FFFF || valid_M !== 1'b1) begin errors++; $display("FAIL mult_mfhi: got %h v=%b want ffffffff/1", AO_M, valid_M); end
  endtask

  task automatic test_multu();
    issue(I_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0, 1'b0);
    tick();
    issue(I_ADD, 32'd0, 32'd0, 32'h1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL multu_busy%0d: got %b want 1", i, busy); end
      tick();
    end
    checks++; if (busy !== 1'b0 || hi_out !== 32'd1 || lo_out !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hilo: got b=%b %h/%h want 0 1/fffffffe", busy, hi_out, lo_out); end
  endtask

  task automatic test_div();
    issue(I_DIV, 32'hFFFF_FFF9, 32'd2, 32'h0, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL div_busy%0d: got %b want 1", i, busy); end
      if (i == 3) begin
        issue(I_MFHI, 32'd0, 32'd0, 32'h0, 1'b1);
        #1;
        checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL div_flush_stall: got %b want 0", md_stall); end
        tick();
        checks++; if (valid_M !== 1'b0) begin errors++; $display("FAIL div_flush_bubble: got %b want 0", valid_M); end
      end else begin
        issue(I_ADD, 32'd0, 32'd0, 32'h100 + 32'(i), 1'b0);
        #1;
        checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL div_add_stall%0d: got %b want 0", i, md_stall); end
        tick();
        checks++; if (valid_M !== 1'b1 || AO_M !== 32'h100 + 32'(i)) begin errors++; $display("FAIL div_add%0d: got v=%b ao=%h want 1/%h", i, valid_M, AO_M, 32'h100 + 32'(i)); end
      end
    end
    checks++; if (busy !== 1'b0 || lo_out !== 32'hFFFF_FFFD || hi_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hilo: got b=%b %h/%h want 0 ffffffff/fffffffd", busy, hi_out, lo_out); end
  endtask

  task automatic test_div_by_zero();
    issue(I_DIVU, 32'd7, 32'd0, 32'h0, 1'b0);
    tick();
    issue(I_ADD, 32'd0, 32'd0, 32'h2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL div0_busy%0d: got %b want 1", i, busy); end
      tick();
    end
    checks++; if (busy !== 1'b0 || hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div0_hilo: got b=%b %h/%h want 0 ffffffff/fffffffd", busy, hi_out, lo_out); end
  endtask

  task automatic test_div_overflow();
    issue(I_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
    tick();
    issue(I_ADD, 32'd0, 32'd0, 32'h3, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    checks++; if (busy !== 1'b0 || lo_out !== 32'h8000_0000 || hi_out !== 32'd0) begin errors++; $display("FAIL divovf_hilo: got b=%b %h/%h want 0 0/80000000", busy, hi_out, lo_out); end
  endtask

  task automatic test_back_to_back();
    issue(I_MTHI, 32'h1234, 32'd0, 32'h0, 1'b0);
    #1;
    checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL mthi_stall: got %b want 0", md_stall); end
    tick();
    checks++; if (hi_out !== 32'h1234) begin errors++; $display("FAIL mthi_hi: got %h want 1234", hi_out); end
    issue(I_MFLO, 32'd0, 32'd0, 32'hDEAD, 1'b0);
    tick();
    checks++; if (AO_M !== 32'h8000_0000 || valid_M !== 1'b1) begin errors++; $display("FAIL mflo_ao: got %h v=%b want 80000000/1", AO_M, valid_M); end
    issue(I_MFHI, 32'd0, 32'd0, 32'hBEEF, 1'b0);
    tick();
    checks++; if (AO_M !== 32'h1234) begin errors++; $display("FAIL mfhi_ao: got %h want 1234", AO_M); end
  endtask

  task automatic test_flush();
    issue(I_MULT, 32'd3, 32'd5, 32'h0, 1'b1);
    tick();
    checks++; if (valid_M !== 1'b0 || IR_M !== 32'd0 || busy !== 1'b0) begin errors++; $display("FAIL flush_mult: got v=%b ir=%h b=%b want 0/0/0", valid_M, IR_M, busy); end
    issue(I_ADD, 32'd0, 32'd0, 32'h4, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    checks++; if (hi_out !== 32'h1234 || lo_out !== 32'h8000_0000 || busy !== 1'b0) begin errors++; $display("FAIL flush_hilo: got b=%b %h/%h want 0 1234/80000000", busy, hi_out, lo_out); end
  endtask

  task automatic test_reset_mid_run();
    issue(I_DIV, 32'd100, 32'd7, 32'h0, 1'b0);
    tick();
    issue(I_ADD, 32'd0, 32'd0, 32'h5, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: got %b want 1", busy); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || valid_M !== 1'b0 || IR_M !== 32'd0 || AO_M !== 32'd0) begin errors++; $display("FAIL rst_mid_out: got b=%b v=%b ir=%h ao=%h want 0", busy, valid_M, IR_M, AO_M); end
    checks++; if (hi_out !== 32'd0 || lo_out !== 32'd0) begin errors++; $display("FAIL rst_mid_hilo: got %h/%h want 0/0", hi_out, lo_out); end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    checks++; if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin errors++; $display("FAIL rst_after: got b=%b %h/%h want 0 0/0", busy, hi_out, lo_out); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_by_zero();
    test_div_overflow();
    test_back_to_back();
    test_flush();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/em_stage_hilo.md
# em_stage_hilo

Parametrised execute/memory pipeline register with an integrated multi-cycle multiply/divide unit and HI/LO register pair. It sits between the E and M stages. It latches the E-stage instruction bundle into M, sources AO_M from HI/LO for mfhi/mflo, and runs mult/multu/div/divu over a configurable number of cycles. While the unit is busy it raises a stall toward the hazard unit and inserts bubbles into M.

## Interface
- WIDTH, 32, datapath width of PC, PC8, RS, RT, AO, HI, LO
- MULT_CYCLES, 5, cycles from mult/multu acceptance to HI/LO update (>=1)
- DIV_CYCLES, 10, cycles from div/divu acceptance to HI/LO update (>=1)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- IR_E  in  32  E-stage instruction (op = IR[31:26], func = IR[5:0])
- PC_E, PC8_E, RS_E, RT_E, AO_E  in  WIDTH each  E-stage PC, PC+8, operands, ALU result
- temp_E  in  1  sideband bit, passed through
- flush_E  in  1  E instruction is squashed; bubble into M, no HI/LO side effect
- IR_M, PC_M, PC8_M, AO_M, RT_M  out  32/WIDTH  registered M-stage bundle
- temp_M  out  1  registered sideband
- valid_M  out  1  M holds a real instruction (0 = bubble)
- busy  out  1  mult/div in progress
- md_stall  out  1  combinational; E instruction must hold this cycle
- hi_out, lo_out  out  WIDTH  current HI/LO

## Operation
- Decode applies only when op==0 (R-type). Funcs: mfhi 0x10, mthi 0x11, mflo 0x12, mtlo 0x13, mult 0x18, multu 0x19, div 0x1A, divu 0x1B. These are the md-class instructions.
- md_stall = busy & md-class(IR_E) & ~flush_E.
- On each rising edge, with reset deasserted:
  - If flush_E or md_stall: M receives a bubble. IR_M, PC_M, PC8_M, AO_M, RT_M and temp_M become 0, and valid_M becomes 0.
  - Otherwise the bundle is copied into M and valid_M becomes 1.
  - AO_M = HI if mfhi, LO if mflo, else AO_E. HI/LO values are those before this edge.
- mthi/mtlo (advancing, not busy): HI or LO <= RS_E on the same edge.
- mult/multu (advancing): the unit latches the 2*WIDTH signed/unsigned product of RS_E × RT_E, loads counter = MULT_CYCLES and sets busy. Results: HI = upper WIDTH bits, LO = lower.
- div/divu (advancing): the unit latches the signed/unsigned quotient (LO) and remainder (HI) of RS_E / RT_E, loads counter = DIV_CYCLES and sets busy.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Overflow case (most-negative / -1): LO = most-negative, HI = 0.
  - Divisor 0: the unit still runs DIV_CYCLES and sets busy, but HI/LO stay unchanged at completion.
- The counter decrements every cycle while busy. On the edge where it goes 1→0, the pending result is written to HI/LO and busy clears.
- A new md op is never accepted while busy, because md_stall blocks it. Non-md instructions keep flowing through while busy.
- flush_E never cancels an operation that is already in progress.
- State: IDLE (busy=0) → RUN (busy=1, counter>0) → IDLE on completion.

## Timing
- Reset (async, while low): all M outputs 0, valid_M 0, HI = LO = 0, busy 0, counter 0, pending result cleared. Reset asserted mid-operation aborts the operation; HI/LO stay 0.
- Pipeline latency: 1 cycle E→M.
- Mult accepted at edge t0:
  - busy = 1 from after t0 through edge t0+MULT_CYCLES.
  - HI/LO update at edge t0+MULT_CYCLES; busy = 0 after it.
  - An mfhi waiting in E advances on edge t0+MULT_CYCLES+1 and reads the new value.
- Div behaves the same with DIV_CYCLES.
- mthi followed immediately by mfhi: mfhi sees the new HI (written one edge earlier).
- flush_E together with md_stall: flush wins. Bubble into M; md_stall is deasserted.

## Test plan
- Reset low mid-run (counter=3): all outputs 0 immediately, without waiting for an edge. After release, busy=0 and HI=LO=0.
- mult RS=0xFFFFFFFF, RT=2, MULT_CYCLES=5, followed by mfhi:
  - md_stall is high for 5 cycles and M sees 5 bubbles (valid_M=0).
  - Then AO_M = 0xFFFFFFFF (HI) and lo_out = 0xFFFFFFFE.
  - multu with the same operands gives HI=1, LO=0xFFFFFFFE.
- div RS=-7, RT=2: after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 leaves HI/LO unchanged and busy lasts 10 cycles.
- mthi RS=0x1234, then mflo and mfhi back-to-back: AO_M = old LO, then 0x1234. No stall.
- During a div: add instructions pass with valid_M=1 and AO_M=AO_E. A flushed mult is issued while idle; busy stays 0 and HI/LO are unchanged.
- Overflow div 0x80000000 / -1: LO=0x80000000, HI=0.
